n64_console_port: RTL and testbench

- Emulates one N64 controller on a single open-drain data line facing an N64 console.
- Decodes console commands and answers with identity bytes or a 32-bit button frame.
- Frame source is a TAS frame FIFO (filled by the serial handler) or a live pass-through word from the real-controller reader.
- One instance per console; all instances share the FIFO write bus.

---
 rtl/n64_console_port_pkg.sv | 32 +++
 rtl/n64_console_port_line_filter.sv | 41 ++++
 rtl/n64_console_port.sv | 206 ++++++++++++++++++++
 tb/tb_n64_console_port.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/n64_console_port_pkg.sv
// n64_pkg: shared constants and types for the N64 console-side controller port.
//   - Console command codes (info, poll, reset).
//   - Identity reply bytes sent for info/reset.
//   - FSM state encoding.
//   - Bit-cell timing multiples, expressed in microseconds.
package n64_pkg;

   localparam logic [7:0] CMD_INFO  = 8'h00;
   localparam logic [7:0] CMD_POLL  = 8'h01;
   localparam logic [7:0] CMD_RESET = 8'hFF;

   localparam logic [7:0] ID_BYTE0 = 8'h05;
   localparam logic [7:0] ID_BYTE1 = 8'h00;
   localparam logic [7:0] ID_BYTE2 = 8'h02;

   // Bit-cell timing multiples of one microsecond.
   localparam int MULT_1  = 1;
   localparam int MULT_2  = 2;
   localparam int MULT_3  = 3;
   localparam int MULT_4  = 4;
   localparam int MULT_10 = 10;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RX_BIT  = 3'd1,
      RX_STOP = 3'd2,
      WAIT    = 3'd3,
      TX_BIT  = 3'd4,
      TX_STOP = 3'd5
   } n64_state_e;

endpackage

// File: rtl/n64_console_port_line_filter.sv
// line_filter: two-flop synchronizer followed by a stability filter.
// Ports:
//   sys_clk  - system clock
//   rst_n    - asynchronous active-low reset (output resets high = idle line)
//   raw      - asynchronous line input
//   filtered - synchronized level; changes only after FILTER_LEN
//              consecutive identical samples that differ from it
module line_filter #(
   parameter int FILTER_LEN = 4
) (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic raw,
   output logic filtered
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    sync;
   logic [CW-1:0] stable_cnt;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync       <= 2'b11;
         stable_cnt <= '0;
         filtered   <= 1'b1;
      end else begin
         sync <= {sync[0], raw};
         // Any sample agreeing with the current output restarts the run.
         if (sync[1] == filtered) begin
            stable_cnt <= '0;
         end else if (stable_cnt == CW'(FILTER_LEN - 1)) begin
            filtered   <= sync[1];
            stable_cnt <= '0;
         end else begin
            stable_cnt <= stable_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/n64_console_port.sv
// n64_console_port: emulates one N64 controller on an open-drain line.
// Receives console commands, answers info/reset with the identity bytes and
// poll with a 32-bit frame taken from the TAS FIFO (or the held frame when
// the FIFO is empty) or from the live pass-through word.
// Ports:
//   sys_clk, rst_n         - clock, asynchronous active-low reset
//   n64d                   - open-drain console line (drives 0 or Z only)
//   real_controller_data   - pass-through frame
//   input_mode             - 1 = TAS FIFO, 0 = pass-through
//   queue_WrEn, queue_data - shared FIFO write bus
//   next_frame_request     - high while the FIFO is not full
//   n64_controller_reset   - synchronous FIFO flush, clears held frame
//   state_dbg              - current FSM state
module n64_console_port
   import n64_pkg::*;
#(
   parameter int CYCLES_PER_US = 50,
   parameter int FIFO_DEPTH    = 16,
   parameter int FILTER_LEN    = 4
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   inout  wire         n64d,
   input  logic [31:0] real_controller_data,
   input  logic        input_mode,
   input  logic        queue_WrEn,
   input  logic [31:0] queue_data,
   output logic        next_frame_request,
   input  logic        n64_controller_reset,
   output n64_state_e  state_dbg
);

   localparam int CNT_W = $clog2(MULT_10 * CYCLES_PER_US + 1);
   localparam int AW    = $clog2(FIFO_DEPTH);

   localparam logic [CNT_W-1:0] CNT_1T      = CNT_W'(MULT_1 * CYCLES_PER_US);
   localparam logic [CNT_W-1:0] CNT_3T      = CNT_W'(MULT_3 * CYCLES_PER_US);
   localparam logic [CNT_W-1:0] SAMPLE_AT   = CNT_W'(MULT_2 * CYCLES_PER_US);
   localparam logic [CNT_W-1:0] TIMEOUT     = CNT_W'(MULT_10 * CYCLES_PER_US);
   localparam logic [CNT_W-1:0] END_2T      = CNT_W'(MULT_2 * CYCLES_PER_US - 1);
   localparam logic [CNT_W-1:0] END_CELL    = CNT_W'(MULT_4 * CYCLES_PER_US - 1);
   localparam logic [AW:0]      FULL_COUNT  = (AW + 1)'(FIFO_DEPTH);

   n64_state_e       state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [3:0]       bit_cnt, bit_cnt_nx;
   logic [7:0]       rx_shift, rx_shift_nx;
   logic [31:0]      tx_shift, tx_shift_nx;
   logic [5:0]       tx_left, tx_left_nx;
   logic             drive_low;
   logic             pop;

   logic line_lvl, line_prev, fall, rise;

   logic [31:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   fifo_count;
   logic          fifo_empty, fifo_full, wr_ok;
   logic [31:0]   fifo_head, held_frame, poll_frame;

   line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .raw      (n64d),
      .filtered (line_lvl)
   );

   assign fall = line_prev & ~line_lvl;
   assign rise = ~line_prev & line_lvl;

   assign n64d      = drive_low ? 1'b0 : 1'bz;
   assign state_dbg = state;

   assign fifo_empty         = (fifo_count == '0);
   assign fifo_full          = (fifo_count == FULL_COUNT);
   assign next_frame_request = ~fifo_full;
   assign wr_ok              = queue_WrEn & ~fifo_full;
   assign fifo_head          = mem[rd_ptr];
   assign poll_frame         = input_mode ? (fifo_empty ? held_frame : fifo_head)
                                          : real_controller_data;

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt + 1'b1;
      bit_cnt_nx  = bit_cnt;
      rx_shift_nx = rx_shift;
      tx_shift_nx = tx_shift;
      tx_left_nx  = tx_left;
      drive_low   = 1'b0;
      pop         = 1'b0;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (fall) begin
               state_nx   = RX_BIT;
               bit_cnt_nx = '0;
            end
         end
         RX_BIT: begin
            // cnt measures time since the last falling edge of the cell.
            if (fall) begin
               cnt_nx = '0;
               if (bit_cnt == 4'd8) state_nx = RX_STOP;
            end else if (cnt == TIMEOUT) begin
               state_nx = IDLE;
            end else if (cnt == SAMPLE_AT && bit_cnt != 4'd8) begin
               rx_shift_nx = {rx_shift[6:0], line_lvl};
               bit_cnt_nx  = bit_cnt + 4'd1;
            end
         end
         RX_STOP: begin
            if (rise) begin
               cnt_nx = '0;
               case (rx_shift)
                  CMD_INFO, CMD_RESET: begin
                     tx_shift_nx = {ID_BYTE0, ID_BYTE1, ID_BYTE2, 8'h00};
                     tx_left_nx  = 6'd24;
                     state_nx    = WAIT;
                  end
                  CMD_POLL: begin
                     tx_shift_nx = poll_frame;
                     tx_left_nx  = 6'd32;
                     pop         = input_mode & ~fifo_empty;
                     state_nx    = WAIT;
                  end
                  default: state_nx = IDLE;
               endcase
            end else if (cnt == TIMEOUT) begin
               state_nx = IDLE;
            end
         end
         WAIT: begin
            if (cnt == END_2T) begin
               cnt_nx   = '0;
               state_nx = TX_BIT;
            end
         end
         TX_BIT: begin
            // Low 1T for a one, 3T for a zero, within a 4T cell.
            drive_low = (cnt < (tx_shift[31] ? CNT_1T : CNT_3T));
            if (cnt == END_CELL) begin
               cnt_nx      = '0;
               tx_shift_nx = {tx_shift[30:0], 1'b0};
               if (tx_left == 6'd1) state_nx = TX_STOP;
               else                 tx_left_nx = tx_left - 6'd1;
            end
         end
         TX_STOP: begin
            drive_low = 1'b1;
            if (cnt == END_2T) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_cnt   <= '0;
         rx_shift  <= '0;
         tx_shift  <= '0;
         tx_left   <= '0;
         line_prev <= 1'b1;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         bit_cnt   <= bit_cnt_nx;
         rx_shift  <= rx_shift_nx;
         tx_shift  <= tx_shift_nx;
         tx_left   <= tx_left_nx;
         line_prev <= line_lvl;
      end
   end

   // FIFO storage carries no reset; only pointers and count define contents.
   always_ff @(posedge sys_clk) begin
      if (wr_ok && !n64_controller_reset) mem[wr_ptr] <= queue_data;
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         held_frame <= '0;
      end else if (n64_controller_reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         held_frame <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr     <= rd_ptr + 1'b1;
            held_frame <= fifo_head;
         end
         case ({wr_ok, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: tb/tb_n64_console_port.sv
// tb_n64_console_port: directed bench for n64_console_port. Plays the console
// on the open-drain line, measures the reply cell by cell and compares it
// against hand-computed words.
module tb_n64_console_port;
   import n64_pkg::*;

   localparam int T = 50;

   logic        sys_clk = 1'b0;
   logic        rst_n = 1'b0;
   wire         n64d;
   logic        console_low = 1'b0;
   logic [31:0] real_controller_data = 32'h0;
   logic        input_mode = 1'b1;
   logic        queue_WrEn = 1'b0;
   logic [31:0] queue_data = 32'h0;
   logic        next_frame_request;
   logic        n64_controller_reset = 1'b0;
   n64_state_e  state_dbg;

   int checks = 0;
   int errors = 0;

   logic [31:0] rx_word;
   int          rx_gap, rx_bad_cells, rx_stop_low;
   logic        rx_timeout;
   int          lows, left_idle;

   pullup (n64d);
   assign n64d = console_low ? 1'b0 : 1'bz;

   always #10 sys_clk = ~sys_clk;

   n64_console_port #(
      .CYCLES_PER_US (T),
      .FIFO_DEPTH    (16),
      .FILTER_LEN    (4)
   ) dut (
      .sys_clk              (sys_clk),
      .rst_n                (rst_n),
      .n64d                 (n64d),
      .real_controller_data (real_controller_data),
      .input_mode           (input_mode),
      .queue_WrEn           (queue_WrEn),
      .queue_data           (queue_data),
      .next_frame_request   (next_frame_request),
      .n64_controller_reset (n64_controller_reset),
      .state_dbg            (state_dbg)
   );

   function automatic logic line_high();
      return (n64d !== 1'b0);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      console_low = 1'b1;
      repeat (b ? T : 3 * T) @(negedge sys_clk);
      console_low = 1'b0;
      repeat (b ? 3 * T : T) @(negedge sys_clk);
   endtask

   task automatic send_cmd(input logic [7:0] c);
      for (int i = 7; i >= 0; i--) send_bit(c[i]);
      console_low = 1'b1;
      repeat (T) @(negedge sys_clk);
      console_low = 1'b0;
   endtask

   // Measures a reply of nbits cells plus its stop bit.
   task automatic capture_reply(input int nbits);
      int lo, hi;
      rx_word = '0; rx_bad_cells = 0; rx_timeout = 1'b0; rx_gap = 0; rx_stop_low = 0;
      do begin
         @(negedge sys_clk);
         rx_gap++;
      end while (line_high() && rx_gap < 400);
      if (line_high()) begin
         rx_timeout = 1'b1;
         return;
      end
      for (int i = 0; i < nbits; i++) begin
         lo = 0; hi = 0;
         while (!line_high() && lo < 400) begin @(negedge sys_clk); lo++; end
         while (line_high() && hi < 400) begin @(negedge sys_clk); hi++; end
         rx_word = {rx_word[30:0], (lo < 2 * T)};
         if (!((lo == T && hi == 3 * T) || (lo == 3 * T && hi == T))) rx_bad_cells++;
         if (lo >= 400 || hi >= 400) begin
            rx_timeout = 1'b1;
            return;
         end
      end
      while (!line_high() && rx_stop_low < 400) begin @(negedge sys_clk); rx_stop_low++; end
   endtask

   task automatic watch_quiet(input int cycles);
      lows = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge sys_clk);
         if (!line_high()) lows++;
      end
   endtask

   task automatic poll_and_check(input string tag, input logic [31:0] exp);
      send_cmd(CMD_POLL);
      capture_reply(32);
      check({tag, "_timeout"}, 32'(rx_timeout), 32'd0);
      check({tag, "_word"}, rx_word, exp);
      check({tag, "_cells"}, 32'(rx_bad_cells), 32'd0);
      check({tag, "_stop"}, 32'(rx_stop_low), 32'(2 * T));
      check({tag, "_idle"}, 32'(state_dbg), 32'(IDLE));
      repeat (20) @(negedge sys_clk);
   endtask

   task automatic write_frame(input logic [31:0] d);
      @(negedge sys_clk);
      queue_WrEn = 1'b1;
      queue_data = d;
      @(negedge sys_clk);
      queue_WrEn = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge sys_clk);
      check("rst_line", 32'(line_high()), 32'd1);
      check("rst_state", 32'(state_dbg), 32'(IDLE));
      check("rst_request", 32'(next_frame_request), 32'd1);
      rst_n = 1'b1;
      repeat (10) @(negedge sys_clk);

      // Info command: identity bytes after a 2T gap
      send_cmd(CMD_INFO);
      capture_reply(24);
      check("info_timeout", 32'(rx_timeout), 32'd0);
      check("info_gap_min", 32'(rx_gap >= 2 * T), 32'd1);
      check("info_gap_max", 32'(rx_gap <= 2 * T + 12), 32'd1);
      check("info_word", rx_word, 32'h0005_0002);
      check("info_cells", 32'(rx_bad_cells), 32'd0);
      check("info_stop", 32'(rx_stop_low), 32'(2 * T));
      repeat (20) @(negedge sys_clk);

      // TAS polls: two FIFO frames, then the held frame repeats
      write_frame(32'h1234_5678);
      write_frame(32'h9ABC_DEF0);
      poll_and_check("tas1", 32'h1234_5678);
      poll_and_check("tas2", 32'h9ABC_DEF0);
      poll_and_check("tas3", 32'h9ABC_DEF0);

      // Pass-through must not pop the queued frame
      write_frame(32'hCAFE_F00D);
      input_mode = 1'b0;
      real_controller_data = 32'h8000_0000;
      poll_and_check("pass", 32'h8000_0000);
      input_mode = 1'b1;
      poll_and_check("pass_nopop", 32'hCAFE_F00D);

      // FIFO full, dropped write, flush
      for (int k = 0; k < 15; k++) write_frame(32'h1000_0000 + 32'(k));
      check("fifo_15_request", 32'(next_frame_request), 32'd1);
      write_frame(32'h1000_000F);
      check("fifo_16_request", 32'(next_frame_request), 32'd0);
      write_frame(32'hDEAD_BEEF);
      check("fifo_17_request", 32'(next_frame_request), 32'd0);
      poll_and_check("fifo_head", 32'h1000_0000);
      check("fifo_pop_request", 32'(next_frame_request), 32'd1);
      write_frame(32'h2000_0000);
      check("fifo_refull_request", 32'(next_frame_request), 32'd0);
      @(negedge sys_clk);
      n64_controller_reset = 1'b1;
      @(negedge sys_clk);
      n64_controller_reset = 1'b0;
      check("flush_request", 32'(next_frame_request), 32'd1);
      poll_and_check("flush_poll", 32'h0000_0000);

      // Two-cycle glitch must not start a bit
      @(negedge sys_clk);
      console_low = 1'b1;
      repeat (2) @(negedge sys_clk);
      console_low = 1'b0;
      left_idle = 0;
      for (int i = 0; i < 20 * T; i++) begin
         @(negedge sys_clk);
         if (state_dbg != IDLE) left_idle++;
      end
      check("glitch_idle", 32'(left_idle), 32'd0);

      // Truncated command times out with no reply
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      check("trunc_busy", 32'(state_dbg), 32'(RX_BIT));
      watch_quiet(8 * T);
      check("trunc_idle", 32'(state_dbg), 32'(IDLE));
      check("trunc_quiet", 32'(lows), 32'd0);

      // Unknown command 0x02
      send_cmd(8'h02);
      watch_quiet(4 * T);
      check("unk_quiet", 32'(lows), 32'd0);
      check("unk_idle", 32'(state_dbg), 32'(IDLE));

      // Reset command starts a reply; async reset mid-reply releases the line
      send_cmd(CMD_RESET);
      rx_gap = 0;
      do begin
         @(negedge sys_clk);
         rx_gap++;
      end while (line_high() && rx_gap < 400);
      check("rstcmd_reply", 32'(rx_gap <= 2 * T + 12), 32'd1);
      check("rstcmd_low", 32'(line_high()), 32'd0);
      repeat (10) @(negedge sys_clk);
      rst_n = 1'b0;
      #1;
      check("midrst_line", 32'(line_high()), 32'd1);
      check("midrst_state", 32'(state_dbg), 32'(IDLE));
      @(negedge sys_clk);
      rst_n = 1'b1;
      repeat (5) @(negedge sys_clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
